writeback_stage: RTL and testbench

//  Registered, parametrised write-back stage. Accepts one retiring instruction from MEM over a

---
 rtl/wb_pkg.sv | 25 ++
 rtl/writeback_stage_load_extender.sv | 47 ++++
 rtl/writeback_stage.sv | 141 ++++++++++++++
 tb/tb_writeback_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: write-data sources, load funct3 codes, FSM states.
package wb_pkg;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_CSR = 2'd2,
        SRC_PC4 = 2'd3
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_extender.sv
// Combinational load aligner: shifts the raw memory word by the byte offset, then
// sign- or zero-extends the selected byte/half/word to the full datapath width.
module load_extender
    import wb_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int OffW      = $clog2(DataWidth / 8)
) (
    input  logic [DataWidth-1:0] data,
    input  logic [2:0]           funct3,
    input  logic [OffW-1:0]      offset,
    output logic [DataWidth-1:0] extended
);

    logic [OffW-1:0]      off_eff;
    logic [DataWidth-1:0] shifted;
    logic signed [7:0]    byte_s;
    logic signed [15:0]   half_s;
    logic signed [31:0]   word_s;

    always_comb begin
        // Halfword/word accesses are naturally aligned, so the low offset bits are dropped.
        off_eff = offset;
        unique case (funct3)
            F3_LH, F3_LHU: off_eff = offset & ~OffW'(1);
            F3_LW, F3_LWU: off_eff = offset & ~OffW'(3);
            F3_LB, F3_LBU: off_eff = offset;
            default:       off_eff = '0;
        endcase

        shifted = data >> {off_eff, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        word_s  = shifted[31:0];

        unique case (funct3)
            F3_LB:   extended = DataWidth'(byte_s);
            F3_LBU:  extended = DataWidth'(shifted[7:0]);
            F3_LH:   extended = DataWidth'(half_s);
            F3_LHU:  extended = DataWidth'(shifted[15:0]);
            F3_LW:   extended = DataWidth'(word_s);
            F3_LWU:  extended = DataWidth'(shifted[31:0]);
            default: extended = data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: holds one retiring instruction, waits for its load data if needed,
// and drives the register-file write port, EX bypass, load-pending flag and retire counter.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddrWidth    = 32,
    parameter int RegAddrWidth = 5,
    parameter int CountWidth   = 32,
    parameter int OffW         = $clog2(DataWidth / 8)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AddrWidth-1:0]    in_instruction_address,
    input  logic [DataWidth-1:0]    in_alu_result,
    input  logic [DataWidth-1:0]    in_csr_read_data,
    input  logic [1:0]              in_regs_write_source,
    input  logic                    in_reg_write_enable,
    input  logic [RegAddrWidth-1:0] in_reg_write_address,
    input  logic [2:0]              in_load_funct3,
    input  logic [OffW-1:0]         in_load_byte_offset,
    input  logic                    mem_rsp_valid,
    input  logic [DataWidth-1:0]    mem_rsp_data,
    input  logic                    flush,
    output logic                    reg_write_enable,
    output logic [RegAddrWidth-1:0] reg_write_address,
    output logic [DataWidth-1:0]    regs_write_data,
    output logic                    fwd_valid,
    output logic [RegAddrWidth-1:0] fwd_address,
    output logic [DataWidth-1:0]    fwd_data,
    output logic                    load_pending,
    output logic [CountWidth-1:0]   retire_count
);

    wb_state_e             state_p0;
    wb_state_e             state_next;
    logic                  accept;
    logic                  accept_is_load;
    logic                  load_done;
    logic [AddrWidth-1:0]  pc_plus4;
    logic [DataWidth-1:0]  pc_plus4_ext;
    logic [DataWidth-1:0]  sel_data;
    logic [DataWidth-1:0]  ext_data;

    logic [2:0]              held_funct3_p0;
    logic [OffW-1:0]         held_offset_p0;
    logic [RegAddrWidth-1:0] held_rd_p0;
    logic                    held_en_p0;

    assign in_ready       = (state_p0 == IDLE || state_p0 == COMMIT) && !flush && !reset;
    assign accept         = in_valid && in_ready;
    assign accept_is_load = wb_src_e'(in_regs_write_source) == SRC_MEM;
    assign load_done      = (state_p0 == WAIT_MEM) && mem_rsp_valid && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_p0 <= IDLE;
        else       state_p0 <= state_next;
    end

    always_comb begin
        state_next = state_p0;
        unique case (state_p0)
            IDLE, COMMIT: begin
                state_next = IDLE;
                if (accept) state_next = accept_is_load ? WAIT_MEM : COMMIT;
            end
            WAIT_MEM: begin
                if (flush)              state_next = IDLE;
                else if (mem_rsp_valid) state_next = COMMIT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pc_plus4     = in_instruction_address + AddrWidth'(4);
    assign pc_plus4_ext = DataWidth'(pc_plus4);

    always_comb begin
        sel_data = '0;
        unique case (wb_src_e'(in_regs_write_source))
            SRC_ALU: sel_data = in_alu_result;
            SRC_CSR: sel_data = in_csr_read_data;
            SRC_PC4: sel_data = pc_plus4_ext;
            default: sel_data = '0;
        endcase
    end

    load_extender #(
        .DataWidth (DataWidth),
        .OffW      (OffW)
    ) u_load_extender (
        .data     (mem_rsp_data),
        .funct3   (held_funct3_p0),
        .offset   (held_offset_p0),
        .extended (ext_data)
    );

    // Stage boundary p0: fields of the accepted instruction, needed only while a load is outstanding.
    always_ff @(posedge clock) begin
        if (accept) begin
            held_funct3_p0 <= in_load_funct3;
            held_offset_p0 <= in_load_byte_offset;
            held_rd_p0     <= in_reg_write_address;
            held_en_p0     <= in_reg_write_enable;
        end
    end

    // Output registers are loaded on the edge that enters COMMIT, so the strobe is visible
    // for exactly the one COMMIT cycle and the counter already includes that instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_enable  <= 1'b0;
            reg_write_address <= '0;
            regs_write_data   <= '0;
            load_pending      <= 1'b0;
            retire_count      <= '0;
        end else begin
            reg_write_enable <= 1'b0;
            load_pending     <= (state_next == WAIT_MEM);
            if (accept) begin
                reg_write_address <= in_reg_write_address;
                if (!accept_is_load) begin
                    reg_write_enable <= in_reg_write_enable && (in_reg_write_address != '0);
                    regs_write_data  <= sel_data;
                    retire_count     <= retire_count + CountWidth'(1);
                end
            end else if (load_done) begin
                reg_write_enable <= held_en_p0 && (held_rd_p0 != '0);
                regs_write_data  <= ext_data;
                retire_count     <= retire_count + CountWidth'(1);
            end
        end
    end

    assign fwd_valid   = reg_write_enable;
    assign fwd_address = reg_write_address;
    assign fwd_data    = regs_write_data;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage (32-bit datapath) with hand-computed expectations.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction_address;
    logic [31:0] in_alu_result;
    logic [31:0] in_csr_read_data;
    logic [1:0]  in_regs_write_source;
    logic        in_reg_write_enable;
    logic [4:0]  in_reg_write_address;
    logic [2:0]  in_load_funct3;
    logic [1:0]  in_load_byte_offset;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        flush;
    logic        reg_write_enable;
    logic [4:0]  reg_write_address;
    logic [31:0] regs_write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_address;
    logic [31:0] fwd_data;
    logic        load_pending;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    writeback_stage dut (
        .clock                  (clock),
        .reset                  (reset),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_instruction_address (in_instruction_address),
        .in_alu_result          (in_alu_result),
        .in_csr_read_data       (in_csr_read_data),
        .in_regs_write_source   (in_regs_write_source),
        .in_reg_write_enable    (in_reg_write_enable),
        .in_reg_write_address   (in_reg_write_address),
        .in_load_funct3         (in_load_funct3),
        .in_load_byte_offset    (in_load_byte_offset),
        .mem_rsp_valid          (mem_rsp_valid),
        .mem_rsp_data           (mem_rsp_data),
        .flush                  (flush),
        .reg_write_enable       (reg_write_enable),
        .reg_write_address      (reg_write_address),
        .regs_write_data        (regs_write_data),
        .fwd_valid              (fwd_valid),
        .fwd_address            (fwd_address),
        .fwd_data               (fwd_data),
        .load_pending           (load_pending),
        .retire_count           (retire_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic offer(input logic [1:0] src, input logic [4:0] rd, input logic en,
                         input logic [31:0] alu, input logic [31:0] csr, input logic [31:0] pc,
                         input logic [2:0] f3, input logic [1:0] off);
        in_valid               = 1'b1;
        in_regs_write_source   = src;
        in_reg_write_address   = rd;
        in_reg_write_enable    = en;
        in_alu_result          = alu;
        in_csr_read_data       = csr;
        in_instruction_address = pc;
        in_load_funct3         = f3;
        in_load_byte_offset    = off;
    endtask

    task automatic check_commit(input string tag, input logic we, input logic [4:0] rd,
                                input logic [31:0] data);
        check_eq({tag, "_we"}, 64'(reg_write_enable), 64'(we));
        check_eq({tag, "_addr"}, 64'(reg_write_address), 64'(rd));
        check_eq({tag, "_data"}, 64'(regs_write_data), 64'(data));
        check_eq({tag, "_count"}, 64'(retire_count), 64'(exp_count));
        check_eq({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(we));
        check_eq({tag, "_fwd_data"}, 64'(fwd_data), 64'(data));
    endtask

    // Accept a load, supply the response after `wait_cycles` pending cycles, check the commit.
    task automatic run_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] rsp,
                            input int wait_cycles, input logic [31:0] exp_data);
        offer(2'd1, rd, 1'b1, 32'h0, 32'h0, 32'h0, f3, off);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            check_eq({tag, "_pending"}, 64'(load_pending), 64'd1);
            check_eq({tag, "_pend_we"}, 64'(reg_write_enable), 64'd0);
            check_eq({tag, "_pend_fwd_addr"}, 64'(fwd_address), 64'(rd));
            check_eq({tag, "_pend_ready"}, 64'(in_ready), 64'd0);
            if (i == wait_cycles - 1) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rsp;
            end
            step();
        end
        mem_rsp_valid = 1'b0;
        exp_count++;
        check_commit(tag, 1'b1, rd, exp_data);
        check_eq({tag, "_pending_clr"}, 64'(load_pending), 64'd0);
        step();
        check_eq({tag, "_after_we"}, 64'(reg_write_enable), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; flush = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        in_instruction_address = '0; in_alu_result = '0; in_csr_read_data = '0;
        in_regs_write_source = '0; in_reg_write_enable = 1'b0; in_reg_write_address = '0;
        in_load_funct3 = '0; in_load_byte_offset = '0;

        @(negedge clock);
        check_eq("rst_ready", 64'(in_ready), 64'd0);
        check_eq("rst_we", 64'(reg_write_enable), 64'd0);
        check_eq("rst_data", 64'(regs_write_data), 64'd0);
        check_eq("rst_count", 64'(retire_count), 64'd0);
        check_eq("rst_pending", 64'(load_pending), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("idle_ready", 64'(in_ready), 64'd1);
        @(negedge clock);

        // ALU result to rd=5
        offer(2'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 3'd0, 2'd0);
        step();
        in_valid = 1'b0;
        exp_count++;
        check_commit("alu", 1'b1, 5'd5, 32'h1234);
        check_eq("commit_ready", 64'(in_ready), 64'd1);
        step();
        check_eq("alu_idle_we", 64'(reg_write_enable), 64'd0);

        run_load("lb", 5'd7, 3'd0, 2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80);
        run_load("lhu", 5'd8, 3'd5, 2'd3, 32'hBEEF_0000, 1, 32'h0000_BEEF);
        run_load("lw", 5'd9, 3'd2, 2'd1, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);
        run_load("lh", 5'd10, 3'd1, 2'd1, 32'h0000_8001, 1, 32'hFFFF_8001);
        run_load("lbu", 5'd11, 3'd4, 2'd3, 32'hA5_000000, 1, 32'h0000_00A5);

        // PC+4 and CSR sources
        offer(2'd3, 5'd3, 1'b1, 32'h0, 32'h0, 32'h100, 3'd0, 2'd0);
        step();
        exp_count++;
        check_commit("pc4", 1'b1, 5'd3, 32'h104);
        offer(2'd2, 5'd4, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0);
        step();
        exp_count++;
        check_commit("csr", 1'b1, 5'd4, 32'hDEAD_BEEF);

        // rd=0 retires without writing
        offer(2'd0, 5'd0, 1'b1, 32'h55, 32'h0, 32'h0, 3'd0, 2'd0);
        step();
        in_valid = 1'b0;
        exp_count++;
        check_eq("rd0_we", 64'(reg_write_enable), 64'd0);
        check_eq("rd0_count", 64'(retire_count), 64'(exp_count));
        step();

        // Four back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            offer(2'd0, 5'(12 + i), 1'b1, 32'h1000 + 32'(i), 32'h0, 32'h0, 3'd0, 2'd0);
            step();
            exp_count++;
            check_commit("b2b", 1'b1, 5'(12 + i), 32'h1000 + 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_eq("b2b_end_we", 64'(reg_write_enable), 64'd0);

        // Flush while waiting for memory, then a stray response in IDLE
        offer(2'd1, 5'd20, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
        step();
        in_valid = 1'b0;
        check_eq("fl_pending", 64'(load_pending), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("fl_pending_clr", 64'(load_pending), 64'd0);
        check_eq("fl_we", 64'(reg_write_enable), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
        step();
        mem_rsp_valid = 1'b0;
        check_eq("fl_stray_we", 64'(reg_write_enable), 64'd0);
        check_eq("fl_count", 64'(retire_count), 64'(exp_count));

        // Flush with a valid offer in IDLE: not accepted
        offer(2'd0, 5'd21, 1'b1, 32'h77, 32'h0, 32'h0, 3'd0, 2'd0);
        flush = 1'b1;
        #1;
        check_eq("fl_idle_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0; flush = 1'b0;
        check_eq("fl_idle_we", 64'(reg_write_enable), 64'd0);
        check_eq("fl_idle_count", 64'(retire_count), 64'(exp_count));

        // Reset while a load is outstanding
        offer(2'd1, 5'd22, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
        step();
        in_valid = 1'b0;
        check_eq("rm_pending", 64'(load_pending), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rm_pending_clr", 64'(load_pending), 64'd0);
        check_eq("rm_count", 64'(retire_count), 64'd0);
        check_eq("rm_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2222_2222;
        step();
        mem_rsp_valid = 1'b0;
        check_eq("rm_rsp_we", 64'(reg_write_enable), 64'd0);
        check_eq("rm_rsp_count", 64'(retire_count), 64'd0);
        check_eq("rm_rsp_data", 64'(regs_write_data), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
